// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } adder_state_t;

  localparam int ADDER_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; count is the carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = a ^ b ^ cin;
  assign count = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: drives one full_adder cell LSB first with a
// registered carry, behind a start/busy/done handshake.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             c_msb_in_q, c_msb_in_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .cin   (c_q),
    .sum   (fa_sum),
    .count (fa_cout)
  );

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sw_d       = sw_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    c_msb_in_d = c_msb_in_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sw_d = (sw_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        c_d  = fa_cout;
        if (cnt_q == CNT_LAST) begin
          c_msb_in_d = c_q;
          state_d    = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        sum_d   = sw_q;
        cout_d  = c_q;
        ovf_d   = c_msb_in_q ^ c_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      sw_q       <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      c_msb_in_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sw_q       <= sw_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      c_msb_in_q <= c_msb_in_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl at WIDTH = 8, 1 and 13.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        st8,  c8,  busy8,  done8,  cout8,  ovf8;
  logic [7:0]  a8,   b8,  sum8;
  logic        st1,  c1,  busy1,  done1,  cout1,  ovf1;
  logic [0:0]  a1,   b1,  sum1;
  logic        st13, c13, busy13, done13, cout13, ovf13;
  logic [12:0] a13,  b13, sum13;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );
  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );
  serial_adder_ctrl #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(st13), .a(a13), .b(b13), .cin(c13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;
    logic [63:0] sum;
  } obs_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t obs(input int w);
    obs_t o;
    case (w)
      1:       begin o.busy = busy1;  o.done = done1;  o.cout = cout1;  o.ovf = ovf1;  o.sum = 64'(sum1);  end
      13:      begin o.busy = busy13; o.done = done13; o.cout = cout13; o.ovf = ovf13; o.sum = 64'(sum13); end
      default: begin o.busy = busy8;  o.done = done8;  o.cout = cout8;  o.ovf = ovf8;  o.sum = 64'(sum8);  end
    endcase
    return o;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [63:0] av,
                        input logic [63:0] bv, input logic ci);
    case (w)
      1:       begin st1  = s; a1  = av[0:0];  b1  = bv[0:0];  c1  = ci; end
      13:      begin st13 = s; a13 = av[12:0]; b13 = bv[12:0]; c13 = ci; end
      default: begin st8  = s; a8  = av[7:0];  b8  = bv[7:0];  c8  = ci; end
    endcase
  endtask

  // Start one addition, scramble the operands after acceptance, wait for done.
  task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, output obs_t r, output int lat, output int bcyc);
    obs_t o;
    @(negedge clk);
    set_in(w, 1'b1, av, bv, ci);
    @(negedge clk);
    set_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~ci);
    lat  = 0;
    bcyc = 0;
    o    = obs(w);
    while (!o.done && lat < 200) begin
      if (o.busy) bcyc++;
      @(negedge clk);
      lat++;
      o = obs(w);
    end
    r = o;
  endtask

  task automatic check_op(input string tag, input int w, input logic [63:0] av,
                          input logic [63:0] bv, input logic ci, input logic [63:0] es,
                          input logic ec, input logic eo);
    obs_t r;
    int   lat, bcyc;
    do_op(w, av, bv, ci, r, lat, bcyc);
    chk({tag, "_lat"},  64'(lat), 64'(w + 1));
    chk({tag, "_busyc"}, 64'(bcyc), 64'(w + 1));
    chk({tag, "_busy_at_done"}, 64'(r.busy), 64'd0);
    chk({tag, "_sum"},  r.sum, es);
    chk({tag, "_cout"}, 64'(r.cout), 64'(ec));
    chk({tag, "_ovf"},  64'(r.ovf), 64'(eo));
    @(negedge clk);
    r = obs(w);
    chk({tag, "_done_1cyc"}, 64'(r.done), 64'd0);
  endtask

  task automatic check_model(input string tag, input int w, input logic [63:0] av,
                             input logic [63:0] bv, input logic ci);
    logic [63:0] mask, am, bm, es;
    logic [64:0] full;
    logic        ec, eo;
    mask = (64'd1 << w) - 64'd1;
    am   = av & mask;
    bm   = bv & mask;
    full = {1'b0, am} + {1'b0, bm} + 65'(ci);
    es   = full[63:0] & mask;
    ec   = full[w];
    eo   = (am[w-1] == bm[w-1]) && (es[w-1] != am[w-1]);
    check_op(tag, w, av, bv, ci, es, ec, eo);
  endtask

  initial begin
    obs_t o;
    int   ndone, first, second;
    logic [63:0] fsum;

    rst = 1'b1;
    set_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
    set_in(1, 1'b0, 64'd0, 64'd0, 1'b0);
    set_in(13, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    o = obs(8);
    chk("rst_busy", 64'(o.busy), 64'd0);
    chk("rst_done", 64'(o.done), 64'd0);
    chk("rst_sum",  o.sum, 64'd0);
    chk("rst_cout", 64'(o.cout), 64'd0);
    chk("rst_ovf",  64'(o.ovf), 64'd0);
    o = obs(13);
    chk("rst_sum13", o.sum, 64'd0);
    rst = 1'b0;

    check_op("5a_3c", 8, 64'h5A, 64'h3C, 1'b0, 64'h96, 1'b0, 1'b1);
    check_op("ff_01", 8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0);
    check_op("ff_ff_c", 8, 64'hFF, 64'hFF, 1'b1, 64'hFF, 1'b1, 1'b0);
    check_op("7f_01", 8, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1);
    check_op("80_80", 8, 64'h80, 64'h80, 1'b0, 64'h00, 1'b1, 1'b1);

    // start held high throughout: results only every WIDTH+2 cycles
    @(negedge clk);
    set_in(8, 1'b1, 64'h12, 64'h34, 1'b0);
    ndone = 0; first = -1; second = -1; fsum = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      o = obs(8);
      if (o.done) begin
        ndone++;
        if (first < 0) begin
          first = i;
          fsum  = o.sum;
        end else if (second < 0) begin
          second = i;
        end
      end
      set_in(8, (i < 29), 64'(i * 37), 64'(i * 11 + 5), i[0]);
    end
    chk("hold_first_sum", fsum, 64'h46);
    chk("hold_first_at", 64'(first), 64'd9);
    chk("hold_period", 64'(second - first), 64'd10);
    chk("hold_ndone", 64'(ndone), 64'd3);
    repeat (2) @(negedge clk);

    // reset in the 4th RUN cycle
    set_in(8, 1'b1, 64'h77, 64'h11, 1'b0);
    @(negedge clk);
    set_in(8, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = obs(8);
    chk("abort_busy", 64'(o.busy), 64'd0);
    chk("abort_sum",  o.sum, 64'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      o = obs(8);
      if (o.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    check_op("after_abort", 8, 64'h01, 64'h01, 1'b0, 64'h02, 1'b0, 1'b0);

    // rst and start together: start dropped
    @(negedge clk);
    rst = 1'b1;
    set_in(8, 1'b1, 64'h05, 64'h06, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    set_in(8, 1'b0, 64'h0, 64'h0, 1'b0);
    o = obs(8);
    chk("rst_start_busy0", 64'(o.busy), 64'd0);
    @(negedge clk);
    o = obs(8);
    chk("rst_start_busy1", 64'(o.busy), 64'd0);

    // WIDTH=1 truth table {a,b,cin} -> sum, cout, ovf(=carry-in to MSB ^ cout)
    check_op("w1_000", 1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    check_op("w1_001", 1, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b1);
    check_op("w1_010", 1, 64'd0, 64'd1, 1'b0, 64'd1, 1'b0, 1'b0);
    check_op("w1_011", 1, 64'd0, 64'd1, 1'b1, 64'd0, 1'b1, 1'b0);
    check_op("w1_100", 1, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0);
    check_op("w1_101", 1, 64'd1, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    check_op("w1_110", 1, 64'd1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1);
    check_op("w1_111", 1, 64'd1, 64'd1, 1'b1, 64'd1, 1'b1, 1'b0);

    check_op("w13_wrap", 13, 64'h1FFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0);
    check_op("w13_ovf",  13, 64'h0FFF, 64'h0001, 1'b0, 64'h1000, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++)
      check_model("rnd8", 8, 64'($urandom), 64'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      check_model("rnd13", 13, 64'($urandom), 64'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
